// File: rtl/decomp_sched.sv
// decomp_sched - job-level controller for the run-length decompressor.
//
// Software programs one job at a time and pulses start. The controller
// fetches compressed 16-bit words from source memory and presents each one
// to the decompressor using the load/done handshake. Every output word the
// decompressor produces is written to destination memory in the same cycle.
// The job ends when out_words words have been written, when the source
// stream is exhausted (error), or when the decompressor stalls for TIMEOUT
// cycles on one word (error). The end of a job is marked by a one-cycle irq
// pulse and a one-cycle dec_clr pulse.
//
// Parameters
//   AW       memory address width, source and destination (pointers wrap)
//   CW       width of the src_len / out_words job counters
//   TIMEOUT  max HOLD cycles without dec_done before an error is raised
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   start                        job start pulse, honoured only in IDLE
//   src_base, src_len            compressed stream location and length
//   dst_base, out_words          output location and length (16-bit words)
//   mem_rd_en/addr/data          source read port, data one cycle after en
//   dec_load, dec_din, dec_done  word handshake towards the decompressor
//   dec_word_valid, dec_dout     decompressor output word
//   dec_clr                      decompressor clear pulse
//   mem_wr_en/addr/data          destination write port (combinational)
//   busy, irq, err               status: not idle, job done pulse, sticky error
//
// Optional feature (macro DECOMP_SCHED_PERF_EN)
//   perf_cycles  busy cycles of the last/current job, saturating
//   perf_stalls  HOLD cycles with dec_done low, saturating
module decomp_sched #(
  parameter int AW      = 16,
  parameter int CW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [CW-1:0] src_len,
  input  logic [AW-1:0] dst_base,
  input  logic [CW-1:0] out_words,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [15:0]   mem_rd_data,
  output logic          dec_load,
  output logic [15:0]   dec_din,
  input  logic          dec_done,
  input  logic          dec_word_valid,
  input  logic [15:0]   dec_dout,
  output logic          dec_clr,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [15:0]   mem_wr_data,
  output logic          busy,
  output logic          irq,
  output logic          err
`ifdef DECOMP_SCHED_PERF_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_stalls
`endif
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_FINISH
  } state_t;

  state_t        state;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] src_len_r;
  logic [CW-1:0] fetched;
  logic [CW-1:0] remaining;
  logic [15:0]   word_r;
  logic [TW-1:0] tcnt;

  logic out_active;
  logic wr_fire;
  logic last_wr;

  // Output words are accepted in every job state except FINISH; the write
  // port is a pure pass-through so the decompressor needs no backpressure.
  assign out_active  = (state == S_CLR) || (state == S_FETCH) ||
                       (state == S_WAIT) || (state == S_HOLD);
  assign wr_fire     = out_active && dec_word_valid && (remaining != '0);
  assign last_wr     = wr_fire && (remaining == CW'(1));

  assign mem_wr_en   = wr_fire;
  assign mem_wr_addr = wr_fire ? wr_ptr : '0;
  assign mem_wr_data = wr_fire ? dec_dout : '0;
  assign mem_rd_addr = rd_ptr;
  assign dec_din     = word_r;

  // Control FSM. Strobe outputs are registered together with the state
  // they belong to, so each is high exactly while its state is current.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      src_len_r <= '0;
      fetched   <= '0;
      remaining <= '0;
      word_r    <= '0;
      tcnt      <= '0;
      mem_rd_en <= 1'b0;
      dec_load  <= 1'b0;
      dec_clr   <= 1'b0;
      busy      <= 1'b0;
      irq       <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      dec_load  <= 1'b0;
      dec_clr   <= 1'b0;
      irq       <= 1'b0;

      if (wr_fire) begin
        wr_ptr    <= wr_ptr + AW'(1);
        remaining <= remaining - CW'(1);
      end

      // The final output word wins over dec_done and the timeout.
      if (last_wr) begin
        state   <= S_FINISH;
        irq     <= 1'b1;
        dec_clr <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              err       <= 1'b0;
              src_len_r <= src_len;
              rd_ptr    <= src_base;
              wr_ptr    <= dst_base;
              remaining <= out_words;
              fetched   <= '0;
              busy      <= 1'b1;
              dec_clr   <= 1'b1;
              if (out_words == '0) begin
                state <= S_FINISH;
                irq   <= 1'b1;
              end else begin
                state <= S_CLR;
              end
            end
          end

          S_CLR: begin
            state     <= S_FETCH;
            mem_rd_en <= (fetched != src_len_r);
          end

          S_FETCH: begin
            if (fetched == src_len_r) begin
              // Source stream exhausted before the output was complete.
              err     <= 1'b1;
              state   <= S_FINISH;
              irq     <= 1'b1;
              dec_clr <= 1'b1;
            end else begin
              rd_ptr  <= rd_ptr + AW'(1);
              fetched <= fetched + CW'(1);
              state   <= S_WAIT;
            end
          end

          S_WAIT: begin
            word_r   <= mem_rd_data;
            tcnt     <= '0;
            dec_load <= 1'b1;
            state    <= S_HOLD;
          end

          S_HOLD: begin
            if (dec_done) begin
              state     <= S_FETCH;
              mem_rd_en <= (fetched != src_len_r);
            end else if (tcnt == TLAST) begin
              err     <= 1'b1;
              state   <= S_FINISH;
              irq     <= 1'b1;
              dec_clr <= 1'b1;
            end else begin
              tcnt     <= tcnt + TW'(1);
              dec_load <= 1'b1;
            end
          end

          S_FINISH: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DECOMP_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if ((state == S_IDLE) && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy) perf_cycles <= sat_inc(perf_cycles);
      if ((state == S_HOLD) && !dec_done) perf_stalls <= sat_inc(perf_stalls);
    end
  end
`endif

endmodule

// File: tb/tb_decomp_sched.sv
module tb_decomp_sched;

  localparam int TO     = 8;
  localparam int BUDGET = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_base = '0;
  logic [15:0] src_len = '0;
  logic [15:0] dst_base = '0;
  logic [15:0] out_words = '0;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [15:0] mem_rd_data = '0;
  logic        dec_load;
  logic [15:0] dec_din;
  logic        dec_done = 1'b0;
  logic        dec_word_valid = 1'b0;
  logic [15:0] dec_dout = '0;
  logic        dec_clr;
  logic        mem_wr_en;
  logic [15:0] mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        busy;
  logic        irq;
  logic        err;

  always #5 clk = ~clk;

  decomp_sched #(.AW(16), .CW(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_base(src_base), .src_len(src_len), .dst_base(dst_base), .out_words(out_words),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .dec_load(dec_load), .dec_din(dec_din), .dec_done(dec_done),
    .dec_word_valid(dec_word_valid), .dec_dout(dec_dout), .dec_clr(dec_clr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .irq(irq), .err(err)
  );

  logic [15:0] mem [0:65535];

  int checks = 0;
  int failures = 0;

  // Scoreboard queues filled by the job model, drained by the monitor.
  logic [15:0] exp_rd[$];
  logic [15:0] exp_din[$];
  logic [31:0] exp_wr[$];
  logic        exp_irq[$];
  int irq_cnt = 0;
  int clr_cnt = 0;

  // Stub decompressor plan: per fetched word, how many output words it
  // emits and how it ends (0: never done, 1: done after emitting,
  // 2: done together with the last emission).
  int          e_arr[16];
  int          d_arr[16];
  logic [15:0] vals[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Source memory: data valid during the cycle after a read strobe,
  // garbage otherwise.
  initial begin : mem_resp
    logic        pend;
    logic [15:0] ra;
    forever begin
      @(negedge clk);
      pend = mem_rd_en;
      ra   = mem_rd_addr;
      @(posedge clk);
      #1;
      mem_rd_data = pend ? mem[ra] : 16'($urandom);
    end
  end

  logic        mon_load_q = 1'b0;
  logic [15:0] mon_din_hold = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mem_rd_en) begin
        chk("rd_expected", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) chk("rd_addr", mem_rd_addr, exp_rd.pop_front());
      end
      if (mem_wr_en) begin
        chk("wr_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) chk("wr_addr_data", {mem_wr_addr, mem_wr_data}, exp_wr.pop_front());
      end
      if (dec_load && !mon_load_q) begin
        chk("din_expected", exp_din.size() > 0, 1);
        if (exp_din.size() > 0) chk("dec_din", dec_din, exp_din.pop_front());
        mon_din_hold = dec_din;
      end else if (dec_load) begin
        chk("dec_din_stable", dec_din, mon_din_hold);
      end
      if (irq) begin
        irq_cnt++;
        chk("clr_with_irq", dec_clr, 1);
        chk("irq_expected", exp_irq.size() > 0, 1);
        if (exp_irq.size() > 0) chk("err_at_irq", err, exp_irq.pop_front());
      end
      if (dec_clr) clr_cnt++;
      mon_load_q = dec_load;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_src(input logic [15:0] sb);
    for (int i = 0; i < 16; i++) mem[16'(sb + 16'(i))] = 16'($urandom);
  endtask

  task automatic plan_clear();
    for (int i = 0; i < 16; i++) begin
      e_arr[i] = 0;
      d_arr[i] = 1;
    end
    for (int i = 0; i < 64; i++) vals[i] = 16'($urandom);
  endtask

  task automatic flush_queues();
    exp_rd.delete();
    exp_din.delete();
    exp_wr.delete();
    exp_irq.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    dec_done = 1'b0;
    dec_word_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [15:0] sb, input int sl, input logic [15:0] db,
                         input int ow, input int poke);
    int cnt, vi, k, h, cyc, irq0, clr0;
    bit fin, ex_err, to_exp;
    logic prev_load;

    // Reference: walk the source words in order and apply the job rules.
    cnt = 0; vi = 0; fin = 0; ex_err = 0; to_exp = 0;
    if (ow != 0) begin
      for (int kk = 0; !fin && !ex_err; kk++) begin
        if (kk == sl) begin
          ex_err = 1;
        end else begin
          exp_rd.push_back(16'(sb + 16'(kk)));
          exp_din.push_back(mem[16'(sb + 16'(kk))]);
          for (int j = 0; j < e_arr[kk] && !fin; j++) begin
            exp_wr.push_back({16'(db + 16'(cnt)), vals[vi]});
            vi++;
            cnt++;
            if (cnt == ow) fin = 1;
          end
          if (!fin && d_arr[kk] == 0) begin
            ex_err = 1;
            to_exp = 1;
          end
        end
      end
    end
    exp_irq.push_back(ex_err);

    irq0 = irq_cnt;
    clr0 = clr_cnt;
    src_base = sb; src_len = 16'(sl); dst_base = db; out_words = 16'(ow);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src_base = 16'($urandom); src_len = 16'($urandom);
    dst_base = 16'($urandom); out_words = 16'($urandom);
    chk("busy_after_start", busy, 1);
    chk("err_cleared_on_start", err, 0);

    k = 0; h = 0; vi = 0; cyc = 0; prev_load = 1'b0;
    while (cyc <= BUDGET) begin
      dec_word_valid = 1'b0;
      dec_done = 1'b0;
      dec_dout = 16'($urandom);
      start = (cyc == poke);
      if (irq) break;
      if (dec_load) begin
        if (!prev_load) h = 0;
        if (h < e_arr[k]) begin
          dec_word_valid = 1'b1;
          dec_dout = vals[vi];
          vi++;
        end
        if (d_arr[k] == 1 && h == e_arr[k]) dec_done = 1'b1;
        if (d_arr[k] == 2 && (h == e_arr[k] - 1 || e_arr[k] == 0)) dec_done = 1'b1;
        h++;
      end else if (prev_load) begin
        k++;
      end
      prev_load = dec_load;
      cyc++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("job_in_budget", cyc <= BUDGET, 1);
    if (cyc > BUDGET) begin
      pulse_reset();
      flush_queues();
      return;
    end
    if (ow == 0) chk("zero_len_irq_latency", cyc, 0);
    if (to_exp) chk("timeout_hold_cycles", h, TO);

    // Output words offered in FINISH and IDLE must be dropped.
    dec_word_valid = 1'b1;
    dec_dout = 16'($urandom);
    @(posedge clk);
    #1;
    chk("busy_idle", busy, 0);
    chk("err_sticky", err, ex_err);
    @(posedge clk);
    #1;
    dec_word_valid = 1'b0;
    chk("irq_pulses", irq_cnt - irq0, 1);
    chk("clr_pulses", clr_cnt - clr0, (ow == 0) ? 1 : 2);
    chk("rd_all_seen", exp_rd.size(), 0);
    chk("wr_all_seen", exp_wr.size(), 0);
    chk("din_all_seen", exp_din.size(), 0);
    chk("irq_all_seen", exp_irq.size(), 0);
    flush_queues();
  endtask

  task automatic reset_mid_hold();
    int cyc, irq0;
    fill_src(16'h0200);
    exp_rd.push_back(16'h0200);
    exp_din.push_back(mem[16'h0200]);
    src_base = 16'h0200; src_len = 16'd4; dst_base = 16'h0300; out_words = 16'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!dec_load && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("reached_hold", dec_load, 1);
    @(posedge clk);
    #1;
    irq0 = irq_cnt;
    rst = 1'b0;
    dec_word_valid = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_dec_load", dec_load, 0);
    chk("rst_dec_din", dec_din, 0);
    chk("rst_rd", {mem_rd_en, mem_rd_addr}, 0);
    chk("rst_wr", {mem_wr_en, mem_wr_addr, mem_wr_data}, 0);
    chk("rst_irq_clr_err", {irq, dec_clr, err}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    dec_word_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("no_irq_on_reset", irq_cnt - irq0, 0);
    chk("idle_after_reset", busy, 0);
    chk("rst_rd_left", exp_rd.size(), 0);
    flush_queues();
  endtask

  initial begin : stim
    int sl, ow;
    logic [15:0] sb, db;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_strobes", {mem_rd_en, dec_load, dec_clr, mem_wr_en, irq, err}, 0);
    chk("reset_addrs", {mem_rd_addr, mem_wr_addr, dec_din}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic job: three words in, one word out after the third.
    plan_clear();
    mem[16'h0010] = 16'h0001; mem[16'h0011] = 16'h0005; mem[16'h0012] = 16'h000B;
    e_arr[2] = 1; vals[0] = 16'hF81F;
    run_job(16'h0010, 3, 16'h0080, 1, -1);

    // Multi-word output from one long run.
    plan_clear(); fill_src(16'h0010);
    e_arr[0] = 4;
    run_job(16'h0010, 3, 16'h0080, 4, -1);

    // Source overrun.
    plan_clear(); fill_src(16'h0040);
    run_job(16'h0040, 2, 16'h0090, 5, -1);

    // Decompressor never signals done.
    plan_clear(); fill_src(16'h0050);
    d_arr[0] = 0;
    run_job(16'h0050, 4, 16'h00A0, 3, -1);

    // Zero-length job.
    plan_clear(); fill_src(16'h0060);
    run_job(16'h0060, 3, 16'h00B0, 0, -1);

    // Last output word and dec_done in the same cycle.
    plan_clear(); fill_src(16'h0070);
    e_arr[0] = 1; e_arr[1] = 1; d_arr[0] = 2; d_arr[1] = 2;
    run_job(16'h0070, 3, 16'h00C0, 2, -1);

    // Address wrap on both pointers.
    plan_clear(); fill_src(16'hFFFE);
    for (int i = 0; i < 4; i++) e_arr[i] = 1;
    run_job(16'hFFFE, 4, 16'hFFFF, 3, -1);

    // start pulsed while busy.
    plan_clear(); fill_src(16'h0100);
    for (int i = 0; i < 4; i++) e_arr[i] = 1;
    run_job(16'h0100, 4, 16'h0180, 4, 3);

    // Reset in HOLD, then a normal job.
    reset_mid_hold();
    plan_clear(); fill_src(16'h0400);
    e_arr[0] = 2; e_arr[1] = 1;
    run_job(16'h0400, 3, 16'h0500, 3, -1);

    // Randomized jobs.
    for (int n = 0; n < 25; n++) begin
      plan_clear();
      sl = $urandom_range(0, 6);
      ow = $urandom_range(0, 6);
      sb = 16'($urandom);
      db = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
        e_arr[i] = $urandom_range(0, 3);
        d_arr[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 2);
      end
      fill_src(sb);
      run_job(sb, sl, db, ow, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
